// File: rtl/minicpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : minicpu_pkg
// Description : Shared definitions for the parametrised mini CPU: opcode
//               constants, FSM state encoding and the instruction-width
//               helper used to size the switch bank.
// Revision    : 1.0 - initial release
// ============================================================================
package minicpu_pkg;

    // Opcodes (instruction bits [INSTR_W-1 -: 3])
    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MULI    = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    // Control FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_CLR  = 2'd2;
    localparam logic [1:0] ST_DISP = 2'd3;

    // Instruction layout: opcode(3) | rd(aw) | rs1(aw) | imm(imm_w)
    function automatic int instr_w(input int aw, input int imm_w);
        return 3 + 2 * aw + imm_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/minicpu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : minicpu_regfile
// Description : NREGS x DATA_W register file, two asynchronous read ports,
//               one synchronous write port, asynchronous active-low clear.
// Ports       : clk, ligar (async clear, active low), we/waddr/wdata (write),
//               raddr1/rdata1, raddr2/rdata2 (combinational reads)
// Revision    : 1.0 - initial release
// ============================================================================
module minicpu_regfile #(
    parameter  int DATA_W = 16,
    parameter  int NREGS  = 16,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              ligar,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NREGS];

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        always_ff @(posedge clk or negedge ligar) begin
            if (!ligar) begin
                regs[i] <= '0;
            end else if (we && (waddr == AW'(i))) begin
                regs[i] <= wdata;
            end
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule
`default_nettype wire

// File: rtl/minicpu_param.sv
`default_nettype none
// ============================================================================
// Module      : minicpu_param
// Description : Switch-driven mini CPU. A release of the active-low enviar
//               button latches the switch word, executes it against the
//               register file and offers the result on a valid/ready port.
// Ports       : clk, ligar (async reset, active low), enviar (button),
//               switches[INSTR_W-1:0], disp_ready (in);
//               disp_valid, disp_op, disp_addr, disp_data, disp_ovf, busy (out)
// Options     : MINICPU_DEBOUNCE_EN - adds a DEBOUNCE_CYC stable-cycle filter
//               after the synchroniser.
// Revision    : 1.0 - initial release
// ============================================================================
module minicpu_param
    import minicpu_pkg::*;
#(
    parameter  int DATA_W       = 16,
    parameter  int NREGS        = 16,
    parameter  int IMM_W        = $clog2(NREGS) + 3,
    parameter  int DEBOUNCE_CYC = 50000,
    localparam int AW           = $clog2(NREGS),
    localparam int INSTR_W      = instr_w(AW, IMM_W)
) (
    input  logic               clk,
    input  logic               ligar,
    input  logic               enviar,
    input  logic [INSTR_W-1:0] switches,
    input  logic               disp_ready,
    output logic               disp_valid,
    output logic [2:0]         disp_op,
    output logic [AW-1:0]      disp_addr,
    output logic [DATA_W-1:0]  disp_data,
    output logic               disp_ovf,
    output logic               busy
);

    localparam int MSB = DATA_W - 1;

    // ------------------------------------------------------------------
    // Button path: 2-FF synchroniser, optional filter, release detector
    // ------------------------------------------------------------------
    logic sync1, sync2, level, level_q, release_pulse;

    always_ff @(posedge clk or negedge ligar) begin
        if (!ligar) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync1   <= enviar;
            sync2   <= sync1;
            level_q <= level;
        end
    end

`ifdef MINICPU_DEBOUNCE_EN
    localparam int DB_LEN = DEBOUNCE_CYC;
`else
    // A zero length selects the pass-through path below.
    localparam int DB_LEN = 0 * DEBOUNCE_CYC;
`endif

    if (DB_LEN > 0) begin : g_debounce
        localparam int CW = $clog2(DB_LEN + 1);
        logic [CW-1:0] cnt;

        // The level follows sync2 only after DB_LEN consecutive cycles of
        // disagreement; any return to agreement restarts the count.
        always_ff @(posedge clk or negedge ligar) begin
            if (!ligar) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_LEN - 1)) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end else begin : g_no_debounce
        assign level = sync2;
    end

    assign release_pulse = level & ~level_q;

    // ------------------------------------------------------------------
    // Instruction latch and field decode
    // ------------------------------------------------------------------
    logic [1:0]         state;
    logic [INSTR_W-1:0] instr;
    logic [AW-1:0]      clr_idx;

    logic [2:0]         op;
    logic [AW-1:0]      rd, rs1, rs2;
    logic [IMM_W-1:0]   imm;

    assign op  = instr[INSTR_W-1 -: 3];
    assign rd  = instr[INSTR_W-4 -: AW];
    assign rs1 = instr[INSTR_W-4-AW -: AW];
    assign imm = instr[IMM_W-1:0];
    assign rs2 = imm[IMM_W-1 -: AW];

    // Sign-magnitude to two's complement; a negative zero negates to 0.
    logic [DATA_W-1:0] imm_mag, imm_ext;
    assign imm_mag = DATA_W'(imm[IMM_W-2:0]);
    assign imm_ext = imm[IMM_W-1] ? (DATA_W'(0) - imm_mag) : imm_mag;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] a, b;
    logic              wr_op;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;

    assign wr_op    = (op != OP_CLEAR) && (op != OP_DISPLAY);
    assign rf_we    = ((state == ST_EXEC) && wr_op) || (state == ST_CLR);
    assign rf_waddr = (state == ST_CLR) ? clr_idx : rd;
    assign rf_wdata = (state == ST_CLR) ? '0 : alu_res;

    minicpu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk    (clk),
        .ligar  (ligar),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (a),
        .rdata2 (b)
    );

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   opnd2, sum, diff;
    logic [2*DATA_W-1:0] prod;
    logic                ovf_add, ovf_sub, ovf_mul;

    assign opnd2 = ((op == OP_ADD) || (op == OP_SUB)) ? b : imm_ext;
    assign sum   = a + opnd2;
    assign diff  = a - opnd2;
    // Operands sign-extended to 2*DATA_W so the product is exact.
    assign prod  = {{DATA_W{a[MSB]}}, a} * {{DATA_W{imm_ext[MSB]}}, imm_ext};

    assign ovf_add = (a[MSB] == opnd2[MSB]) && (sum[MSB]  != a[MSB]);
    assign ovf_sub = (a[MSB] != opnd2[MSB]) && (diff[MSB] != a[MSB]);
    // Truncation is lossless only if every bit above the kept sign bit
    // replicates it.
    assign ovf_mul = (prod[2*DATA_W-1:MSB] != '0) && (prod[2*DATA_W-1:MSB] != '1);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_LOAD:           alu_res = imm_ext;
            OP_ADD, OP_ADDI:   begin alu_res = sum;  alu_ovf = ovf_add; end
            OP_SUB, OP_SUBI:   begin alu_res = diff; alu_ovf = ovf_sub; end
            OP_MULI:           begin alu_res = prod[DATA_W-1:0]; alu_ovf = ovf_mul; end
            OP_DISPLAY:        alu_res = a;
            default:           alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM and display registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge ligar) begin
        if (!ligar) begin
            state      <= ST_IDLE;
            instr      <= '0;
            clr_idx    <= '0;
            disp_valid <= 1'b0;
            disp_op    <= '0;
            disp_addr  <= '0;
            disp_data  <= '0;
            disp_ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (release_pulse) begin
                        instr <= switches;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    disp_op   <= op;
                    disp_addr <= (op == OP_DISPLAY) ? rs1 :
                                 (op == OP_CLEAR)   ? '0  : rd;
                    disp_data <= alu_res;
                    disp_ovf  <= alu_ovf;
                    clr_idx   <= '0;
                    if (op == OP_CLEAR) begin
                        state <= ST_CLR;
                    end else begin
                        state      <= ST_DISP;
                        disp_valid <= 1'b1;
                    end
                end
                ST_CLR: begin
                    if (clr_idx == AW'(NREGS - 1)) begin
                        state      <= ST_DISP;
                        disp_valid <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + AW'(1);
                    end
                end
                ST_DISP: begin
                    if (disp_ready) begin
                        disp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/minicpu_param.md
Name: minicpu_param

Overview:
- Parametrised next-generation switch-driven mini CPU.
- Operator sets an instruction on the switches and releases the active-low `enviar` button. The block then latches the instruction, executes it against an internal register file, and presents the result on a valid/ready display port for the LCD driver.
- Adds over the first generation:
  - configurable data width and register count
  - registered instruction latch
  - multi-cycle CLEAR operation
  - overflow flag
  - display handshake

Parameters:
- DATA_W, 16, register/ALU data width (>= 8).
- NREGS, 16, register count, power of two, >= 4; AW = clog2(NREGS).
- IMM_W, AW+3, immediate field width: MSB is sign, remaining IMM_W-1 bits are magnitude.
- DEBOUNCE_CYC, 50000, stable-cycle count for the debouncer (1 ms at 50 MHz); used only with the optional feature.

Ports:
- clk  in  1  system clock (50 MHz).
- ligar  in  1  asynchronous, active-low reset.
- enviar  in  1  send button, active low, asynchronous to clk.
- switches  in  INSTR_W = 3+2*AW+IMM_W  instruction fields, MSB first:
  - opcode[2:0]
  - rd[AW]
  - rs1[AW]
  - imm[IMM_W]; rs2 is the top AW bits of imm.
- disp_ready  in  1  LCD driver accepts the result.
- disp_valid  out  1  result available.
- disp_op  out  3  opcode of the completed instruction.
- disp_addr  out  AW  rd, or rs1 for DISPLAY.
- disp_data  out  DATA_W  written or displayed value.
- disp_ovf  out  1  signed overflow or truncation occurred.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: while ligar is low, all of the following are 0:
  - state = IDLE
  - every register file entry
  - instruction latch
  - synchroniser flops
  - all outputs
- Reset taking effect mid-operation abandons the instruction: no partial write, and disp_valid drops immediately.
- Input path: `enviar` passes through a 2-FF synchroniser. A release is the synchronised 0->1 edge, giving a 1-cycle pulse.
- Immediate extension: sign-magnitude to two's complement at DATA_W. A negative zero yields 0.
- Opcodes (arithmetic is modulo 2^DATA_W, signed):
  - 000 LOAD: rd <= imm
  - 001 ADD: rd <= rs1 + rs2
  - 010 ADDI: rd <= rs1 + imm
  - 011 SUB: rd <= rs1 - rs2
  - 100 SUBI: rd <= rs1 - imm
  - 101 MULI: rd <= low DATA_W bits of rs1 * imm
  - 110 CLEAR: all registers <= 0
  - 111 DISPLAY: no write; disp_data = rs1
- disp_ovf:
  - ADD/ADDI/SUB/SUBI: set on signed overflow.
  - MULI: set if the truncated product differs from the full product.
  - All other opcodes: 0.
- State machine:
  - IDLE: on a release pulse, latch switches into the instruction register and go to EXEC. Releases seen in any other state are discarded (no queueing).
  - EXEC (1 cycle): read operands from the latched instruction; the register file is read combinationally. Capture result and ovf into the output registers. Write rd on the edge ending EXEC for opcodes 000-101. Next state is CLR for CLEAR, otherwise DISP.
  - CLR: a counter writes 0 to index 0..NREGS-1, one per cycle (NREGS cycles), then goes to DISP with disp_data = 0 and disp_addr = 0.
  - DISP: disp_valid = 1, with disp_op/addr/data/ovf held stable. When disp_valid && disp_ready: the transfer completes, disp_valid drops next cycle, and state returns to IDLE. disp_ready may be held high permanently.
- Latency, for a write opcode with disp_ready high: release pulse at cycle T, EXEC at T+1, register written and disp_valid high at T+2, back to IDLE at T+3.
- The destination may equal a source (rd == rs1 or rd == rs2): the operand is the old value.
- The output registers hold their last values in IDLE.

Optional Feature:
- Macro: MINICPU_DEBOUNCE_EN.
- Defined: after synchronisation, a counter requires `enviar` to be stable for DEBOUNCE_CYC consecutive cycles before updating the debounced level. The release edge is taken from the debounced level, so glitches shorter than DEBOUNCE_CYC are ignored.
- Undefined: synchroniser only; the edge is taken directly from the synchronised signal.

Decomposition:
- Package minicpu_pkg holds:
  - opcode localparams OP_LOAD..OP_DISPLAY
  - FSM state encoding (IDLE, EXEC, CLR, DISP)
  - a function computing INSTR_W from AW and IMM_W
- One sub-module, minicpu_regfile: NREGS x DATA_W, 2 asynchronous read ports, 1 synchronous write port, asynchronous active-low clear on ligar.

Test Plan (DATA_W=16, NREGS=16, IMM_W=7, disp_ready=1 unless noted):
- LOAD r3,+5 then release -> disp_valid 2 cycles after the pulse, disp_data=0x0005, disp_addr=3; DISPLAY r3 then gives 0x0005.
- LOAD r1,+63; LOAD r2,-1; ADD r4=r1+r2 -> r4=0x003E, ovf=0; SUBI r5=r2-(-0) -> r5=0xFFFF.
- LOAD r1,+63; MULI r1 by 63 six times -> ovf=1 on the first truncation, and disp_data equals the reference model modulo 2^16.
- Hold disp_ready=0 for 20 cycles -> disp_valid and data stay stable and busy=1; a second release during this time is ignored; when ready rises, exactly one handshake occurs, then IDLE.
- CLEAR after loading r0..r15 -> busy held for 1+16 cycles, then disp_data=0; DISPLAY of any register returns 0.
- Assert ligar low during CLR at index 7 -> outputs go to 0 immediately; all registers read 0 after reset is released. With MINICPU_DEBOUNCE_EN and DEBOUNCE_CYC=8: a 3-cycle enviar glitch produces no execution.
